// File: rtl/uart_loader_if.sv
// Byte-stream and memory debug-port signals of the UART boot loader.
interface uart_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        dbg_mem_op;
  logic [3:0]  dbg_wren;
  logic [31:0] dbg_adr;
  logic [31:0] dbg_do;
  logic        dbg_ack;

  // Loader side
  modport master (
    input  rx_data, rx_valid, tx_ready, dbg_ack,
    output tx_data, tx_valid, dbg_mem_op, dbg_wren, dbg_adr, dbg_do
  );

  // UART / memory side
  modport slave (
    output rx_data, rx_valid, tx_ready, dbg_ack,
    input  tx_data, tx_valid, dbg_mem_op, dbg_wren, dbg_adr, dbg_do
  );
endinterface

// File: rtl/uart_loader.sv
// UART boot loader: parses SYNC/ADDR/CNT/DATA/CSUM frames from a byte
// stream, writes words through the memory debug port, answers ACK/NAK and
// releases the CPU reset after a clean load.
module uart_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC           = 8'hA5,
  parameter bit          BOOT_RUN       = 1'b0
) (
  input  logic          clk,
  input  logic          n_reset,
  uart_loader_if.master bus,
  output logic          cpu_n_reset,
  output logic          busy
);
  localparam logic [7:0]  ACK      = 8'h06;
  localparam logic [7:0]  NAK      = 8'h15;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CNT, S_DATA, S_WRITE, S_CSUM, S_RESP
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_word;
  logic [31:0] r_tmo;
  logic [31:0] r_dbg_adr;
  logic [31:0] r_dbg_do;
  logic [15:0] r_cnt;
  logic [1:0]  r_idx;
  logic [7:0]  r_csum;
  logic [7:0]  r_skid;
  logic        r_skid_full;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_mem_op;
  logic        r_run;

  logic        w_bv;
  logic [7:0]  w_b;
  logic [31:0] w_word;
  logic [15:0] w_cnt;
  logic        w_frame;
  logic        w_tmo;

  // Byte source for frame states: a held skid byte is older than the wire.
  always_comb begin
    w_bv    = r_skid_full | bus.rx_valid;
    w_b     = r_skid_full ? r_skid : bus.rx_data;
    w_word  = {w_b, r_word[31:8]};
    w_cnt   = {w_b, r_cnt[15:8]};
    w_frame = (r_state == S_ADDR) || (r_state == S_CNT) ||
              (r_state == S_DATA) || (r_state == S_CSUM);
    w_tmo   = !w_bv && (r_tmo == TMO_LAST);
  end

  // Frame parser, skid register, timeout and all registered outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_word      <= '0;
      r_tmo       <= '0;
      r_dbg_adr   <= '0;
      r_dbg_do    <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_csum      <= '0;
      r_skid      <= '0;
      r_skid_full <= 1'b0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_mem_op    <= 1'b0;
      r_run       <= BOOT_RUN;
    end else begin
      // Outside WRITE the skid drains one byte per cycle; a byte arriving
      // in the same cycle takes its place so nothing is lost.
      if (r_state != S_WRITE && r_skid_full) begin
        if (bus.rx_valid) r_skid <= bus.rx_data;
        else              r_skid_full <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.rx_valid && bus.rx_data == SYNC) begin
            r_state <= S_ADDR;
            r_run   <= 1'b0;
            r_csum  <= '0;
            r_idx   <= '0;
            r_tmo   <= '0;
          end
        end

        S_ADDR: begin
          if (w_bv) begin
            r_addr <= {w_b, r_addr[31:8]};
            r_csum <= r_csum + w_b;
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_state <= S_CNT;
          end
        end

        S_CNT: begin
          if (w_bv) begin
            r_cnt  <= w_cnt;
            r_csum <= r_csum + w_b;
            if (r_idx == 2'd1) begin
              r_idx   <= '0;
              r_state <= (w_cnt == 16'd0) ? S_CSUM : S_DATA;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end

        S_DATA: begin
          if (w_bv) begin
            r_word <= w_word;
            r_csum <= r_csum + w_b;
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_state   <= S_WRITE;
              r_mem_op  <= 1'b1;
              r_dbg_adr <= r_addr;
              r_dbg_do  <= w_word;
            end
          end
        end

        S_WRITE: begin
          if (bus.rx_valid && r_skid_full) begin
            // Overrun: the in-flight write is dropped along with the frame.
            r_state     <= S_RESP;
            r_tx_valid  <= 1'b1;
            r_tx_data   <= NAK;
            r_skid_full <= 1'b0;
            r_mem_op    <= 1'b0;
            r_dbg_adr   <= '0;
            r_dbg_do    <= '0;
          end else begin
            if (bus.rx_valid) begin
              r_skid      <= bus.rx_data;
              r_skid_full <= 1'b1;
            end
            if (bus.dbg_ack) begin
              r_mem_op  <= 1'b0;
              r_dbg_adr <= '0;
              r_dbg_do  <= '0;
              r_addr    <= r_addr + 32'd4;
              r_cnt     <= r_cnt - 16'd1;
              r_state   <= (r_cnt == 16'd1) ? S_CSUM : S_DATA;
            end
          end
        end

        S_CSUM: begin
          if (w_bv) begin
            r_state     <= S_RESP;
            r_tx_valid  <= 1'b1;
            r_tx_data   <= (w_b == r_csum) ? ACK : NAK;
            r_skid_full <= 1'b0;
          end
        end

        S_RESP: begin
          if (bus.tx_ready) begin
            r_state    <= S_IDLE;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_run      <= (r_tx_data == ACK);
          end
        end

        default: r_state <= S_IDLE;
      endcase

      // Inter-byte timeout; a byte in the expiry cycle restarts the count.
      if (w_frame) begin
        if (w_bv) begin
          r_tmo <= '0;
        end else if (w_tmo) begin
          r_state    <= S_RESP;
          r_tx_valid <= 1'b1;
          r_tx_data  <= NAK;
        end else begin
          r_tmo <= r_tmo + 32'd1;
        end
      end
    end
  end

  assign bus.tx_data    = r_tx_data;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.dbg_mem_op = r_mem_op;
  assign bus.dbg_wren   = r_mem_op ? 4'hF : 4'h0;
  assign bus.dbg_adr    = r_dbg_adr;
  assign bus.dbg_do     = r_dbg_do;
  assign cpu_n_reset    = r_run;
  assign busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: table of whole frames plus hand-written timeout,
// reset and noise sequences; writes and responses go through scoreboards.
module tb_uart_loader;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic cpu_n_reset;
  logic busy;

  uart_loader_if bus ();

  uart_loader #(
    .TIMEOUT_CYCLES(100),
    .SYNC          (8'hA5),
    .BOOT_RUN      (1'b0)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .bus        (bus),
    .cpu_n_reset(cpu_n_reset),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t        exp_wr_q [$];
  logic [7:0] exp_tx_q [$];
  int         ack_delay = 0;
  int         ack_wait  = 0;
  wr_t        got_wr;

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t t;
    t.adr = a;
    t.dat = d;
    exp_wr_q.push_back(t);
  endtask

  // Memory model: acks each request after ack_delay idle cycles.
  always @(negedge clk) begin
    if (!n_reset) begin
      bus.dbg_ack = 1'b0;
      ack_wait    = 0;
    end else if (bus.dbg_ack) begin
      bus.dbg_ack = 1'b0;
      chk("dbg_release", 32'({bus.dbg_mem_op, bus.dbg_wren}), 32'h0);
    end else if (bus.dbg_mem_op) begin
      if (ack_wait >= ack_delay) begin
        ack_wait    = 0;
        bus.dbg_ack = 1'b1;
        chk("dbg_wren", 32'(bus.dbg_wren), 32'hF);
        if (exp_wr_q.size() == 0) begin
          chk("write_pending", 32'(exp_wr_q.size() != 0), 32'h1);
        end else begin
          got_wr = exp_wr_q.pop_front();
          chk("dbg_adr", bus.dbg_adr, got_wr.adr);
          chk("dbg_do", bus.dbg_do, got_wr.dat);
        end
      end else begin
        ack_wait++;
      end
    end else begin
      ack_wait = 0;
    end
  end

  // UART transmitter model: accepts each response byte one cycle later.
  always @(negedge clk) begin
    if (!n_reset) begin
      bus.tx_ready = 1'b0;
    end else if (bus.tx_ready) begin
      bus.tx_ready = 1'b0;
    end else if (bus.tx_valid) begin
      if (exp_tx_q.size() == 0)
        chk("tx_pending", 32'(exp_tx_q.size() != 0), 32'h1);
      else
        chk("tx_data", 32'(bus.tx_data), 32'(exp_tx_q.pop_front()));
      bus.tx_ready = 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] fr [16], input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      send_byte(fr[i]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy || bus.tx_valid) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_idle"}, 32'(k < 2000), 32'h1);
    @(negedge clk);
  endtask

  // Counts rising edges from the last byte until tx_valid is seen.
  task automatic time_nak(input string name);
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!bus.tx_valid && k < 300);
    chk(name, 32'(k), 32'd100);
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_tx_valid"}, 32'(bus.tx_valid), 32'h0);
    chk({name, "_tx_data"}, 32'(bus.tx_data), 32'h0);
    chk({name, "_mem_op"}, 32'(bus.dbg_mem_op), 32'h0);
    chk({name, "_wren"}, 32'(bus.dbg_wren), 32'h0);
    chk({name, "_adr"}, bus.dbg_adr, 32'h0);
    chk({name, "_do"}, bus.dbg_do, 32'h0);
    chk({name, "_busy"}, 32'(busy), 32'h0);
    chk({name, "_cpu_n_reset"}, 32'(cpu_n_reset), 32'h0);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  b [16];
    int          len;
    int          gap;
    int          ack_dly;
    logic [7:0]  resp;
    logic        run;
    int          nwr;
    logic [31:0] wadr [2];
    logic [31:0] wdat [2];
  } vec_t;

  localparam int NV = 6;
  vec_t       vecs [NV];
  logic [7:0] f_good [16];
  logic [7:0] f_bad [16];
  logic [7:0] f_empty [16];
  logic [7:0] f_wrap [16];

  task automatic set_vec(input int r, input string nm, input logic [7:0] fr [16],
                         input int len, input int gap, input int ack,
                         input logic [7:0] resp, input logic run, input int nwr,
                         input logic [31:0] a0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [31:0] d1);
    vecs[r].name    = nm;
    vecs[r].b       = fr;
    vecs[r].len     = len;
    vecs[r].gap     = gap;
    vecs[r].ack_dly = ack;
    vecs[r].resp    = resp;
    vecs[r].run     = run;
    vecs[r].nwr     = nwr;
    vecs[r].wadr[0] = a0;
    vecs[r].wdat[0] = d0;
    vecs[r].wadr[1] = a1;
    vecs[r].wdat[1] = d1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    f_good  = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h13,
                8'h04, 8'h00, 8'h00, 8'h93, 8'h04, 8'h00, 8'h00, 8'hB2};
    f_bad   = f_good;
    f_bad[15] = 8'hB3;
    f_empty = '{0: 8'hA5, default: 8'h00};
    f_wrap  = '{8'hA5, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h44,
                8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55, 8'h5F};

    //          name       frame    len gap ack resp   run  nwr
    set_vec(0, "good",    f_good,  16, 2, 0, 8'h06, 1'b1, 2,
            32'h0002_0000, 32'h0000_0413, 32'h0002_0004, 32'h0000_0493);
    set_vec(1, "badsum",  f_bad,   16, 2, 0, 8'h15, 1'b0, 2,
            32'h0002_0000, 32'h0000_0413, 32'h0002_0004, 32'h0000_0493);
    set_vec(2, "empty",   f_empty,  8, 2, 0, 8'h06, 1'b1, 0,
            32'h0, 32'h0, 32'h0, 32'h0);
    set_vec(3, "wrap",    f_wrap,  16, 2, 1, 8'h06, 1'b1, 2,
            32'hFFFF_FFFC, 32'h1122_3344, 32'h0000_0000, 32'h5566_7788);
    set_vec(4, "skid",    f_good,  16, 4, 8, 8'h06, 1'b1, 2,
            32'h0002_0000, 32'h0000_0413, 32'h0002_0004, 32'h0000_0493);
    set_vec(5, "overrun", f_good,  16, 2, 8, 8'h15, 1'b0, 0,
            32'h0, 32'h0, 32'h0, 32'h0);

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    n_reset      = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("por");
    n_reset = 1'b1;
    @(negedge clk);

    for (int r = 0; r < NV; r++) begin
      ack_delay = vecs[r].ack_dly;
      for (int w = 0; w < vecs[r].nwr; w++) push_wr(vecs[r].wadr[w], vecs[r].wdat[w]);
      exp_tx_q.push_back(vecs[r].resp);
      for (int i = 0; i < vecs[r].len; i++) begin
        send_byte(vecs[r].b[i]);
        if (i == 0) begin
          chk({vecs[r].name, "_busy"}, 32'(busy), 32'h1);
          chk({vecs[r].name, "_cpu_hold"}, 32'(cpu_n_reset), 32'h0);
        end
        repeat (vecs[r].gap) @(negedge clk);
      end
      wait_idle(vecs[r].name);
      chk({vecs[r].name, "_writes_left"}, 32'(exp_wr_q.size()), 32'h0);
      chk({vecs[r].name, "_resp_left"}, 32'(exp_tx_q.size()), 32'h0);
      chk({vecs[r].name, "_cpu_n_reset"}, 32'(cpu_n_reset), 32'(vecs[r].run));
      exp_wr_q.delete();
      exp_tx_q.delete();
    end
    ack_delay = 0;

    // Timeout after three address bytes.
    exp_tx_q.push_back(8'h15);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h02);
    time_nak("timeout_100");
    wait_idle("timeout");
    chk("timeout_cpu_n_reset", 32'(cpu_n_reset), 32'h0);
    chk("timeout_resp_left", 32'(exp_tx_q.size()), 32'h0);

    // A byte landing on the expiry cycle wins and restarts the count.
    exp_tx_q.push_back(8'h15);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h02);
    repeat (98) @(negedge clk);
    send_byte(8'h00);
    time_nak("timeout_restart");
    wait_idle("timeout2");
    chk("timeout2_resp_left", 32'(exp_tx_q.size()), 32'h0);

    // Reset after five bytes.
    send_frame(f_good, 5, 2);
    chk("mid_busy", 32'(busy), 32'h1);
    n_reset = 1'b0;
    #1;
    chk_reset_outs("rst5");
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);

    // Reset with a write in flight.
    ack_delay = 1000;
    send_frame(f_good, 11, 2);
    chk("inflight_mem_op", 32'(bus.dbg_mem_op), 32'h1);
    chk("inflight_adr", bus.dbg_adr, 32'h0002_0000);
    chk("inflight_do", bus.dbg_do, 32'h0000_0413);
    n_reset = 1'b0;
    #1;
    chk_reset_outs("rstwr");
    @(negedge clk);
    n_reset = 1'b1;
    ack_delay = 0;
    @(negedge clk);

    // Noise in IDLE, then a clean load.
    send_byte(8'h00);
    chk("noise00_busy", 32'(busy), 32'h0);
    send_byte(8'hFF);
    chk("noiseFF_busy", 32'(busy), 32'h0);
    push_wr(32'h0002_0000, 32'h0000_0413);
    push_wr(32'h0002_0004, 32'h0000_0493);
    exp_tx_q.push_back(8'h06);
    send_frame(f_good, 16, 2);
    wait_idle("reload");
    chk("reload_writes_left", 32'(exp_wr_q.size()), 32'h0);
    chk("reload_resp_left", 32'(exp_tx_q.size()), 32'h0);
    chk("reload_cpu_n_reset", 32'(cpu_n_reset), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000: inter-byte timeout, in clk cycles, inside a frame.
REQ-002 Parameter SYNC, default 8'hA5: frame start byte.
REQ-003 Parameter BOOT_RUN, default 0: reset value of cpu_n_reset.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 n_reset  in  1  asynchronous, active-low reset.
REQ-006 rx_data  in  8  received byte from UART receiver.
REQ-007 rx_valid  in  1  one-cycle strobe; rx_data valid.
REQ-008 tx_data  out  8  response byte to UART transmitter.
REQ-009 tx_valid  out  1  response byte offered; held until tx_ready.
REQ-010 tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready.
REQ-011 dbg_mem_op  out  1  memory debug-port request; held until dbg_ack.
REQ-012 dbg_wren  out  4  byte write enables; 4'hF during a request, else 0.
REQ-013 dbg_adr  out  32  write address.
REQ-014 dbg_do  out  32  write data.
REQ-015 dbg_ack  in  1  memory completed the write this cycle.
REQ-016 cpu_n_reset  out  1  CPU reset, active-low.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 Frame format: SYNC, ADDR[4] little-endian, CNT[2] little-endian, CNT words of 4 bytes each little-endian, CSUM[1].
REQ-019 States: IDLE, ADDR, CNT, DATA, WRITE, CSUM, RESP.
REQ-020 IDLE: bytes other than SYNC are ignored; SYNC -> ADDR, drives cpu_n_reset=0, clears the checksum accumulator.
REQ-021 ADDR takes 4 bytes, then -> CNT; CNT takes 2 bytes, then -> DATA if CNT!=0, else -> CSUM.
REQ-022 DATA: the 4th byte of a word -> WRITE; dbg_mem_op=1, dbg_wren=4'hF, dbg_adr=current address and dbg_do=word are asserted the cycle after that byte and held until dbg_ack.
REQ-023 On dbg_ack, all dbg_* outputs deassert the next cycle and the address increments by 4, with 32-bit wrap-around (FFFFFFFC -> 00000000).
REQ-024 After dbg_ack, the FSM -> DATA if words remain, else -> CSUM.
REQ-025 One-entry skid register: a byte arriving in WRITE is latched and consumed on exit from WRITE.
REQ-026 Overrun: a second byte arriving while the skid register is full aborts the frame -> RESP with NAK.
REQ-027 Checksum = 8-bit modulo-256 sum of all bytes after SYNC, up to but excluding CSUM.
REQ-028 CSUM: a match -> RESP with ACK 8'h06; a mismatch -> RESP with NAK 8'h15.
REQ-029 RESP: tx_valid=1 with tx_data held; on tx_ready -> IDLE.
REQ-030 On leaving RESP with ACK, cpu_n_reset=1; with NAK, cpu_n_reset stays 0.
REQ-031 Words already written are not rolled back on NAK.
REQ-032 Timeout: in ADDR, CNT, DATA or CSUM, TIMEOUT_CYCLES cycles with no rx_valid -> RESP with NAK.
REQ-033 The timeout counter restarts on every accepted byte and is frozen in WRITE.
REQ-034 Bytes arriving in RESP are dropped.
REQ-035 rx_valid coincident with a timeout expiry: the byte wins and the counter restarts.

Reset
REQ-036 While n_reset=0, all outputs are asynchronously driven to: tx_valid=0, tx_data=0, dbg_mem_op=0, dbg_wren=0, dbg_adr=0, dbg_do=0, busy=0, cpu_n_reset=BOOT_RUN.
REQ-037 While n_reset=0, the FSM is held in IDLE and the skid register, checksum and counters are cleared.
REQ-038 Reset mid-frame discards the partial frame; a write in flight is abandoned.

Verification
REQ-039 Good load: A5 00 00 02 00 02 00 13 04 00 00 93 04 00 00 B2 -> two writes, (20000, 00000413) then (20004, 00000493), dbg_wren=F -> tx 06 -> cpu_n_reset=1.
REQ-040 Bad checksum: same frame with CSUM B3 -> both writes occur -> tx 15 -> cpu_n_reset stays 0.
REQ-041 Empty frame: A5 00 00 00 00 00 00 00 -> no dbg_mem_op pulse -> tx 06.
REQ-042 Timeout (TIMEOUT_CYCLES=100): A5 then 3 address bytes, then silence -> tx 15 exactly 100 cycles after the last byte -> IDLE.
REQ-043 Skid and overrun: dbg_ack delayed 8 cycles; one byte in WRITE -> frame completes normally; two bytes in WRITE -> tx 15.
REQ-044 Mid-frame reset and noise: n_reset pulsed low after 5 bytes -> outputs at reset values; stray 00 FF bytes in IDLE ignored; a full good frame then -> tx 06.
